inv_seq_checker: RTL and testbench
==================================

# inv_seq_checker

Synthesizable stimulus sequencer and response checker for a single-bit inverting DUT. It is the hardware counterpart of the inverter self-check bench: it drives the DUT input from a fixed vector list, waits a programmable settle time, samples the DUT output, and grades it against the inverted stimulus. It sits beside the DUT in the environment top level. Pass/fail counts and per-vector result strobes feed status logic or the waveform dump.

## Interface
- NUM_VEC, 4, number of stimulus vectors (1..32)
- VECTORS, 4'b0101, stimulus bits, vector k = VECTORS[k]; the default applies 1,0,1,0
- SETTLE, 100, cycles dut_a is held before the sample cycle (>= 1)
- CNT_W, $clog2(NUM_VEC+1), width of the count outputs
- IDX_W, max($clog2(NUM_VEC),1), width of the index outputs

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- dut_a  out  1  stimulus driven to the DUT input
- dut_y  in  1  DUT output under check
- busy  out  1  high in SETTLE and CHECK
- done  out  1  high in DONE, held until next accepted start or rst
- res_valid  out  1  one-cycle strobe per graded vector
- res_pass  out  1  grade of the strobed vector, valid with res_valid
- res_idx  out  IDX_W  index of the strobed vector
- pass_cnt  out  CNT_W  vectors passed in the current or last run
- fail_cnt  out  CNT_W  vectors failed in the current or last run
- any_fail  out  1  sticky, set on first failure of a run
- first_fail_idx  out  IDX_W  index of first failing vector; 0 if none

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1 -> SETTLE:
  - vec_idx=0, dut_a=VECTORS[0], settle counter=SETTLE-1
  - pass_cnt, fail_cnt, any_fail, first_fail_idx cleared; done cleared
- SETTLE: counter decrements each cycle; on counter==0 -> CHECK.
- CHECK, one cycle: at the edge leaving CHECK, dut_y is sampled and graded.
  - pass iff dut_y === ~dut_a; X/Z on dut_y grades as fail.
  - res_valid=1, res_pass, res_idx=vec_idx registered at that edge; the strobe lasts one cycle.
  - pass_cnt or fail_cnt increments.
  - On the first fail: any_fail=1, first_fail_idx=vec_idx.
  - If vec_idx==NUM_VEC-1 -> DONE, done=1.
  - Else vec_idx+1, dut_a=VECTORS[vec_idx+1], counter=SETTLE-1 -> SETTLE.
- DONE: dut_a holds the last vector; results hold until the next accepted start.
- start in SETTLE/CHECK: ignored, with no effect on the run.
- rst, at any time including mid-run: state IDLE, all outputs 0.
- Counts cannot overflow, because CNT_W covers NUM_VEC.

## Timing
- Reset value of every output: 0 (dut_a=0, busy=0, done=0, res_valid=0, counts 0).
- Let E0 be the edge that samples start=1.
  - dut_a=VECTORS[k] is stable from edge E0+k·(SETTLE+1).
  - dut_y for vector k is sampled at edge E0+(k+1)·(SETTLE+1), after SETTLE+1 full cycles of stable stimulus.
  - res_valid is high for the cycle following that edge.
- The final vector's res_valid and the done rise coincide in the same cycle.
- Run length: NUM_VEC·(SETTLE+1) cycles from E0 to done.
- busy=1 from E0 until the edge that sets done.
- start on the same edge that enters DONE is not honoured.
- start held high in DONE restarts on the next edge.

## Test plan
- Ideal inverter DUT (dut_y=~dut_a), defaults:
  - res_valid at E0+101, +202, +303, +404
  - all res_pass=1, res_idx 0..3
  - pass_cnt=4, fail_cnt=0, any_fail=0, done=1 after 404 cycles
- DUT stuck-at-0, defaults:
  - res_pass sequence 1,0,1,0
  - pass_cnt=2, fail_cnt=2, any_fail=1, first_fail_idx=1
- Non-inverting buffer DUT, SETTLE=3:
  - four fails at E0+4, 8, 12, 16
  - fail_cnt=4, first_fail_idx=0
- Inverter with 3-cycle registered delay:
  - SETTLE=3: all pass
  - SETTLE=1: vectors 1..3 fail, so fail_cnt=3, first_fail_idx=1
- start pulsed at E0+50 (defaults) -> no change to timing or counts; rst at E0+150 -> all outputs 0, state IDLE, next start runs a full clean run.
- After DONE with fail_cnt=2, start again with an ideal DUT -> counts cleared on the accepted edge, then ending pass_cnt=4, fail_cnt=0, any_fail=0.

Source files
------------

// File: rtl/inv_seq_checker.sv
// Stimulus sequencer and response checker for a single-bit inverting DUT.
// Walks a fixed vector list, waits SETTLE cycles per vector, then grades dut_y against ~dut_a.
module inv_seq_checker #(
   parameter int                 NUM_VEC = 4,
   parameter logic [NUM_VEC-1:0] VECTORS = 4'b0101,
   parameter int                 SETTLE  = 100,
   parameter int                 CNT_W   = $clog2(NUM_VEC + 1),
   parameter int                 IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   output logic             dut_a_o,
   input  logic             dut_y_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             res_valid_o,
   output logic             res_pass_o,
   output logic [IDX_W-1:0] res_idx_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic             any_fail_o,
   output logic [IDX_W-1:0] first_fail_idx_o
);

   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [SET_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
   logic [IDX_W-1:0] nxt_idx_s;
   logic             dut_a_q, dut_a_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             res_valid_q, res_valid_d;
   logic             res_pass_q, res_pass_d;
   logic [IDX_W-1:0] res_idx_q, res_idx_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             any_fail_q, any_fail_d;
   logic [IDX_W-1:0] ffi_q, ffi_d;
   logic             pass_s;

   // Case equality so an X/Z on dut_y grades as a failure in simulation.
   assign pass_s    = (dut_y_i === ~dut_a_q);
   assign nxt_idx_s = vec_idx_q + IDX_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) state_d = S_SETTLE;
            else         state_d = state_q;
         end
         S_SETTLE: begin
            if (cnt_q == '0) state_d = S_CHECK;
            else             state_d = S_SETTLE;
         end
         S_CHECK: begin
            if (vec_idx_q == LAST_IDX) state_d = S_DONE;
            else                       state_d = S_SETTLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      vec_idx_d   = vec_idx_q;
      dut_a_d     = dut_a_q;
      busy_d      = busy_q;
      done_d      = done_q;
      res_valid_d = 1'b0;
      res_pass_d  = res_pass_q;
      res_idx_d   = res_idx_q;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      any_fail_d  = any_fail_q;
      ffi_d       = ffi_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               vec_idx_d  = '0;
               dut_a_d    = VECTORS[0];
               cnt_d      = SETTLE_LD;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_cnt_d = '0;
               fail_cnt_d = '0;
               any_fail_d = 1'b0;
               ffi_d      = '0;
            end else begin
               busy_d = 1'b0;
            end
         end
         S_SETTLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - SET_W'(1);
            else             cnt_d = cnt_q;
         end
         S_CHECK: begin
            res_valid_d = 1'b1;
            res_pass_d  = pass_s;
            res_idx_d   = vec_idx_q;
            if (pass_s) begin
               pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
               fail_cnt_d = fail_cnt_q + CNT_W'(1);
               if (!any_fail_q) begin
                  any_fail_d = 1'b1;
                  ffi_d      = vec_idx_q;
               end else begin
                  any_fail_d = any_fail_q;
               end
            end
            // The last vector's grade and done land on the same edge.
            if (vec_idx_q == LAST_IDX) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end else begin
               vec_idx_d = nxt_idx_s;
               dut_a_d   = VECTORS[nxt_idx_s];
               cnt_d     = SETTLE_LD;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         vec_idx_q   <= '0;
         dut_a_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_pass_q  <= 1'b0;
         res_idx_q   <= '0;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         any_fail_q  <= 1'b0;
         ffi_q       <= '0;
      end else begin
         cnt_q       <= cnt_d;
         vec_idx_q   <= vec_idx_d;
         dut_a_q     <= dut_a_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         res_valid_q <= res_valid_d;
         res_pass_q  <= res_pass_d;
         res_idx_q   <= res_idx_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         any_fail_q  <= any_fail_d;
         ffi_q       <= ffi_d;
      end
   end

   assign dut_a_o          = dut_a_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign res_valid_o      = res_valid_q;
   assign res_pass_o       = res_pass_q;
   assign res_idx_o        = res_idx_q;
   assign pass_cnt_o       = pass_cnt_q;
   assign fail_cnt_o       = fail_cnt_q;
   assign any_fail_o       = any_fail_q;
   assign first_fail_idx_o = ffi_q;

endmodule

// File: tb/tb_inv_seq_checker.sv
// Bench for inv_seq_checker: three instances (SETTLE 100/3/1) with behavioural DUT models,
// a table of runs and a scoreboard of expected per-vector strobes.
module tb_inv_seq_checker;

   typedef struct {
      int   idx;
      logic pass;
      int   cyc;
   } exp_t;

   typedef struct {
      int         inst;
      int         mode;
      bit         pre_rst;
      logic [3:0] mask;
      int         pc;
      int         fc;
      int         af;
      int         ffi;
   } run_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_r;
   int         mode[3];
   logic       a_w[3], busy_w[3], done_w[3], rv_w[3], rp_w[3], af_w[3];
   logic [1:0] ridx_w[3], ffi_w[3];
   logic [2:0] pc_w[3], fc_w[3];
   logic [3:0] vec_c = 4'b0101;

   exp_t sb[$];
   run_t tbl[6];
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   // mode 0 inverter, 1 stuck-at-0, 2 buffer, 3 inverter behind a 3-flop delay line
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int S = (g == 0) ? 100 : ((g == 1) ? 3 : 1);
      logic [2:0] dly;
      logic       y_s;
      always @(posedge clk) begin
         if (rst) dly <= 3'b111;
         else     dly <= {dly[1:0], a_w[g]};
      end
      always_comb begin
         case (mode[g])
            0:       y_s = ~a_w[g];
            1:       y_s = 1'b0;
            2:       y_s = a_w[g];
            default: y_s = ~dly[2];
         endcase
      end
      inv_seq_checker #(.SETTLE(S)) u_dut (
         .clk_i(clk), .rst_i(rst), .start_i(start_r[g]),
         .dut_a_o(a_w[g]), .dut_y_i(y_s),
         .busy_o(busy_w[g]), .done_o(done_w[g]),
         .res_valid_o(rv_w[g]), .res_pass_o(rp_w[g]), .res_idx_o(ridx_w[g]),
         .pass_cnt_o(pc_w[g]), .fail_cnt_o(fc_w[g]),
         .any_fail_o(af_w[g]), .first_fail_idx_o(ffi_w[g])
      );
   end

   function automatic int settle_of(input int i);
      return (i == 0) ? 100 : ((i == 1) ? 3 : 1);
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic take_strobe(input int i, input int el);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_strobe: inst %0d idx %0d at cycle %0d, none expected", i, ridx_w[i], el);
      end else begin
         e = sb.pop_front();
         chk("res_idx", int'(ridx_w[i]), e.idx);
         chk("res_pass", int'(rp_w[i]), int'(e.pass));
         chk("res_cycle", el, e.cyc);
      end
   endtask

   task automatic chk_all_zero(input int i, input string tag);
      chk({tag, "_dut_a"}, int'(a_w[i]), 0);
      chk({tag, "_busy"}, int'(busy_w[i]), 0);
      chk({tag, "_done"}, int'(done_w[i]), 0);
      chk({tag, "_res_valid"}, int'(rv_w[i]), 0);
      chk({tag, "_pass_cnt"}, int'(pc_w[i]), 0);
      chk({tag, "_fail_cnt"}, int'(fc_w[i]), 0);
      chk({tag, "_any_fail"}, int'(af_w[i]), 0);
      chk({tag, "_ffi"}, int'(ffi_w[i]), 0);
   endtask

   task automatic do_run(input run_t r, input bit hold);
      int i;
      int s;
      int el;
      exp_t e;
      i = r.inst;
      s = settle_of(i);
      mode[i] = r.mode;
      if (r.pre_rst) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
      start_r[i] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         e.idx  = k;
         e.pass = r.mask[k];
         e.cyc  = (k + 1) * (s + 1);
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) start_r[i] = 1'b0;
      chk("start_busy", int'(busy_w[i]), 1);
      chk("start_done", int'(done_w[i]), 0);
      chk("start_pass_cnt", int'(pc_w[i]), 0);
      chk("start_fail_cnt", int'(fc_w[i]), 0);
      chk("start_any_fail", int'(af_w[i]), 0);
      chk("start_dut_a", int'(a_w[i]), int'(vec_c[0]));
      el = 0;
      while (el < 4 * (s + 1) + 20) begin
         @(negedge clk);
         el++;
         if (rv_w[i]) take_strobe(i, el);
         if (done_w[i]) break;
      end
      chk("done_seen", int'(done_w[i]), 1);
      chk("run_length", el, 4 * (s + 1));
      chk("sb_drained", sb.size(), 0);
      chk("end_pass_cnt", int'(pc_w[i]), r.pc);
      chk("end_fail_cnt", int'(fc_w[i]), r.fc);
      chk("end_any_fail", int'(af_w[i]), r.af);
      chk("end_ffi", int'(ffi_w[i]), r.ffi);
      chk("end_busy", int'(busy_w[i]), 0);
      chk("end_dut_a", int'(a_w[i]), int'(vec_c[3]));
      sb.delete();
   endtask

   initial begin
      int   el;
      exp_t e;
      run_t r;
      rst     = 1'b1;
      start_r = 3'b000;
      for (int i = 0; i < 3; i++) mode[i] = 0;

      //            inst mode rst  mask    pc fc af ffi
      tbl[0] = '{0, 0, 1'b0, 4'b1111, 4, 0, 0, 0};
      tbl[1] = '{0, 1, 1'b0, 4'b0101, 2, 2, 1, 1};
      tbl[2] = '{0, 0, 1'b0, 4'b1111, 4, 0, 0, 0};
      tbl[3] = '{1, 2, 1'b0, 4'b0000, 0, 4, 1, 0};
      tbl[4] = '{1, 3, 1'b0, 4'b1111, 4, 0, 0, 0};
      tbl[5] = '{2, 3, 1'b1, 4'b0001, 1, 3, 1, 1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_all_zero(i, "reset");

      for (int t = 0; t < 6; t++) do_run(tbl[t], 1'b0);

      // Stray start mid-run, then reset mid-run.
      mode[0] = 0;
      e.idx = 0; e.pass = 1'b1; e.cyc = 101;
      sb.push_back(e);
      start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      el = 0;
      while (el < 150) begin
         @(negedge clk);
         el++;
         if (rv_w[0]) take_strobe(0, el);
         if (el == 101) begin
            chk("mid_pass_cnt", int'(pc_w[0]), 1);
            chk("mid_busy", int'(busy_w[0]), 1);
            chk("mid_dut_a", int'(a_w[0]), int'(vec_c[1]));
         end
         start_r[0] = (el == 49) ? 1'b1 : 1'b0;
         if (el == 149) rst = 1'b1;
      end
      chk_all_zero(0, "midrst");
      chk("midrst_sb", sb.size(), 0);
      sb.delete();
      rst = 1'b0;
      @(negedge clk);
      do_run(tbl[0], 1'b0);

      // start held high: not honoured on the edge entering DONE, restarts on the next.
      r = '{1, 0, 1'b0, 4'b1111, 4, 0, 0, 0};
      do_run(r, 1'b1);
      @(negedge clk);
      chk("restart_busy", int'(busy_w[1]), 1);
      chk("restart_done", int'(done_w[1]), 0);
      chk("restart_pass_cnt", int'(pc_w[1]), 0);
      chk("restart_dut_a", int'(a_w[1]), int'(vec_c[0]));
      start_r[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
